// File: rtl/usb_pkg.sv
// Shared USB TX definitions: request codes, PID bytes, FSM states and the
// helpers that map a request code to its PID byte and packet class.
package usb_pkg;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_DATA0 = 3'd1,
    PKT_DATA1 = 3'd2,
    PKT_ACK   = 3'd3,
    PKT_NAK   = 3'd4,
    PKT_STALL = 3'd5
  } tx_pkt_e;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [7:0] SYNC_BYTE  = 8'h80;
  localparam int         MAX_PACKET = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_PID    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC_LO = 3'd4,
    ST_CRC_HI = 3'd5,
    ST_EOP    = 3'd6
  } tx_state_e;

  function automatic logic [7:0] pid_byte(input logic [2:0] t);
    case (t)
      PKT_DATA0: return PID_DATA0;
      PKT_DATA1: return PID_DATA1;
      PKT_ACK:   return PID_ACK;
      PKT_NAK:   return PID_NAK;
      PKT_STALL: return PID_STALL;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic logic is_data_pkt(input logic [2:0] t);
    return (t == PKT_DATA0) || (t == PKT_DATA1);
  endfunction

endpackage

// File: rtl/tx_packet_ctrl_if.sv
// Buffer/encoder-facing signals of the TX packet controller.
interface tx_packet_ctrl_if;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       byte_req;
  logic       eop_done;
  logic       get_tx_packet_data;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       eop_req;
  logic       tx_busy;
  logic       tx_error;

  // slave is the controller; master is the buffer/encoder side driving it
  modport slave (
    input  tx_packet, buffer_occupancy, tx_packet_data, byte_req, eop_done,
    output get_tx_packet_data, tx_byte, tx_byte_valid, eop_req, tx_busy, tx_error
  );
  modport master (
    output tx_packet, buffer_occupancy, tx_packet_data, byte_req, eop_done,
    input  get_tx_packet_data, tx_byte, tx_byte_valid, eop_req, tx_busy, tx_error
  );
endinterface

// File: rtl/crc16_usb.sv
// USB CRC16 (poly 0x8005 reflected, init 0xFFFF), one byte per enabled cycle.
module crc16_usb (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    // LSB-first: reflected polynomial 0xA001
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      crc <= 16'hFFFF;
    else if (clear)  crc <= 16'hFFFF;
    else if (enable) crc <= crc_byte(crc, data);
  end

endmodule

// File: rtl/tx_packet_ctrl.sv
// USB TX packet sequencer: SYNC, PID, payload, inverted CRC16, EOP handshake
// with the encoder, popping the packet buffer one byte per consumed DATA byte.
module tx_packet_ctrl
  import usb_pkg::*;
(
  input  logic            clk,
  input  logic            n_rst,
  tx_packet_ctrl_if.slave bus
);

  tx_state_e   state, state_nxt;
  logic [2:0]  pkt_type;
  logic [6:0]  remaining;
  logic [6:0]  len_in;
  logic [15:0] crc;
  logic [7:0]  tx_byte_d;
  logic        req_legal, req_illegal, underflow, pop, crc_clear, tx_error_q;

  assign req_legal   = (bus.tx_packet != PKT_NONE) && (bus.tx_packet <= PKT_STALL);
  assign req_illegal = bus.tx_packet > PKT_STALL;
  assign len_in      = (bus.buffer_occupancy > 7'(MAX_PACKET)) ? 7'(MAX_PACKET)
                                                               : bus.buffer_occupancy;

  // An empty buffer mid-payload aborts straight to EOP and suppresses the pop
  assign underflow = (state == ST_DATA) && (remaining != 7'd0) && (bus.buffer_occupancy == 7'd0);
  assign pop       = bus.byte_req && (state == ST_DATA) && !underflow;
  assign crc_clear = (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_legal) state_nxt = ST_SYNC;
      ST_SYNC:   if (bus.byte_req) state_nxt = ST_PID;
      ST_PID:
        if (bus.byte_req) begin
          if (is_data_pkt(pkt_type)) state_nxt = (remaining != 7'd0) ? ST_DATA : ST_CRC_LO;
          else                       state_nxt = ST_EOP;
        end
      ST_DATA:
        if (underflow)                        state_nxt = ST_EOP;
        else if (pop && remaining == 7'd1)    state_nxt = ST_CRC_LO;
      ST_CRC_LO: if (bus.byte_req) state_nxt = ST_CRC_HI;
      ST_CRC_HI: if (bus.byte_req) state_nxt = ST_EOP;
      ST_EOP:    if (bus.eop_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      pkt_type   <= 3'd0;
      remaining  <= 7'd0;
      tx_error_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_error_q <= ((state == ST_IDLE) && req_illegal) || underflow;
      if ((state == ST_IDLE) && req_legal) begin
        pkt_type  <= bus.tx_packet;
        remaining <= is_data_pkt(bus.tx_packet) ? len_in : 7'd0;
      end else if (pop) begin
        remaining <= remaining - 7'd1;
      end
    end
  end

  crc16_usb u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (crc_clear),
    .enable (pop),
    .data   (bus.tx_packet_data),
    .crc    (crc)
  );

  always_comb begin
    tx_byte_d = 8'h00;
    case (state)
      ST_SYNC:   tx_byte_d = SYNC_BYTE;
      ST_PID:    tx_byte_d = pid_byte(pkt_type);
      ST_DATA:   tx_byte_d = bus.tx_packet_data;
      ST_CRC_LO: tx_byte_d = ~crc[7:0];
      ST_CRC_HI: tx_byte_d = ~crc[15:8];
      default:   tx_byte_d = 8'h00;
    endcase
  end

  assign bus.tx_byte            = tx_byte_d;
  assign bus.get_tx_packet_data = pop;
  assign bus.tx_byte_valid      = (state == ST_SYNC) || (state == ST_PID) || (state == ST_DATA) ||
                                  (state == ST_CRC_LO) || (state == ST_CRC_HI);
  assign bus.eop_req            = (state == ST_EOP);
  assign bus.tx_busy            = (state != ST_IDLE);
  assign bus.tx_error           = tx_error_q;

endmodule

// File: tb/tb_tx_packet_ctrl.sv
// Directed bench for tx_packet_ctrl: encoder/buffer model driven on the
// falling edge, outputs sampled there or shortly after the rising edge.
module tb_tx_packet_ctrl;

  logic tb_clk = 1'b0;
  logic n_rst  = 1'b0;
  always #5 tb_clk = ~tb_clk;

  tx_packet_ctrl_if bus();

  tx_packet_ctrl dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int   checks = 0, failures = 0;
  int   pops = 0, errs = 0;
  int   pops_base = 0, buf_len = 0;
  logic ovr_en = 1'b0;

  always @(posedge tb_clk) if (bus.get_tx_packet_data === 1'b1) pops <= pops + 1;
  always @(negedge tb_clk) if (bus.tx_error === 1'b1) errs <= errs + 1;

  // Buffer model: head byte is its index, occupancy shrinks with each pop
  assign bus.tx_packet_data   = 8'(pops - pops_base);
  assign bus.buffer_occupancy = ovr_en ? 7'd0 : 7'(buf_len - (pops - pops_base));

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic send_req(input logic [2:0] code);
    @(negedge tb_clk); bus.tx_packet = code;
    @(negedge tb_clk); bus.tx_packet = 3'd0;
  endtask

  task automatic get_byte(output logic [7:0] b, output logic ok);
    int n;
    n = 0;
    while (bus.tx_byte_valid !== 1'b1 && n < 40) begin @(negedge tb_clk); n++; end
    ok = (bus.tx_byte_valid === 1'b1);
    b  = bus.tx_byte;
    bus.byte_req = 1'b1;
    @(negedge tb_clk);
    bus.byte_req = 1'b0;
  endtask

  task automatic finish_eop(output logic ok);
    int n;
    n = 0;
    while (bus.eop_req !== 1'b1 && n < 40) begin @(negedge tb_clk); n++; end
    ok = (bus.eop_req === 1'b1);
    bus.eop_done = 1'b1;
    @(negedge tb_clk);
    bus.eop_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.tx_packet = 3'd6; bus.byte_req = 1'b0; bus.eop_done = 1'b0;
    repeat (2) @(negedge tb_clk);
    checks++;
    if ({bus.get_tx_packet_data, bus.tx_byte_valid, bus.eop_req, bus.tx_busy, bus.tx_error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got %b exp 00000", {bus.get_tx_packet_data, bus.tx_byte_valid,
               bus.eop_req, bus.tx_busy, bus.tx_error});
    end
    checks++;
    if (bus.tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got %h exp 00", bus.tx_byte); end
    bus.tx_packet = 3'd0;
    n_rst = 1'b1;
    @(negedge tb_clk);
  endtask

  task automatic test_ack();
    logic [7:0] exp [2] = '{8'h80, 8'hD2};
    logic [7:0] b; logic ok; int p0;
    p0 = pops;
    send_req(3'd3);
    foreach (exp[i]) begin
      get_byte(b, ok); checks++;
      if (!ok || b !== exp[i]) begin failures++; $display("FAIL ack_byte%0d got %h exp %h", i, b, exp[i]); end
    end
    checks++;
    if (bus.eop_req !== 1'b1 || bus.tx_byte_valid !== 1'b0) begin
      failures++; $display("FAIL ack_eop eop_req=%b valid=%b exp 1/0", bus.eop_req, bus.tx_byte_valid);
    end
    finish_eop(ok); checks++;
    if (!ok || bus.tx_busy !== 1'b0) begin failures++; $display("FAIL ack_idle ok=%b busy=%b exp 1/0", ok, bus.tx_busy); end
    checks++;
    if (pops - p0 != 0) begin failures++; $display("FAIL ack_pops got %0d exp 0", pops - p0); end
  endtask

  task automatic test_data0_zero();
    logic [7:0] exp [4] = '{8'h80, 8'hC3, 8'h00, 8'h00};
    logic [7:0] b; logic ok;
    buf_len = 0; pops_base = pops;
    send_req(3'd1);
    foreach (exp[i]) begin
      get_byte(b, ok); checks++;
      if (!ok || b !== exp[i]) begin failures++; $display("FAIL zlp_byte%0d got %h exp %h", i, b, exp[i]); end
    end
    finish_eop(ok); checks++;
    if (!ok) begin failures++; $display("FAIL zlp_eop got eop_req=0 exp 1"); end
    checks++;
    if (pops - pops_base != 0) begin failures++; $display("FAIL zlp_pops got %0d exp 0", pops - pops_base); end
  endtask

  task automatic test_data1_full();
    logic [7:0] b; logic ok; logic [15:0] crc;
    buf_len = 64; pops_base = pops; crc = 16'hFFFF;
    send_req(3'd2);
    get_byte(b, ok); checks++;
    if (!ok || b !== 8'h80) begin failures++; $display("FAIL d1_sync got %h exp 80", b); end
    get_byte(b, ok); checks++;
    if (!ok || b !== 8'h4B) begin failures++; $display("FAIL d1_pid got %h exp 4b", b); end
    for (int i = 0; i < 64; i++) begin
      get_byte(b, ok); checks++;
      if (!ok || b !== 8'(i)) begin failures++; $display("FAIL d1_data%0d got %h exp %h", i, b, 8'(i)); end
      crc = crc_model(crc, 8'(i));
    end
    crc = ~crc;
    get_byte(b, ok); checks++;
    if (!ok || b !== crc[7:0]) begin failures++; $display("FAIL d1_crc_lo got %h exp %h", b, crc[7:0]); end
    get_byte(b, ok); checks++;
    if (!ok || b !== crc[15:8]) begin failures++; $display("FAIL d1_crc_hi got %h exp %h", b, crc[15:8]); end
    finish_eop(ok); checks++;
    if (!ok) begin failures++; $display("FAIL d1_eop got eop_req=0 exp 1"); end
    checks++;
    if (pops - pops_base != 64) begin failures++; $display("FAIL d1_pops got %0d exp 64", pops - pops_base); end
  endtask

  task automatic test_underflow();
    logic [7:0] exp [4] = '{8'h80, 8'hC3, 8'h00, 8'h01};
    logic [7:0] b; logic ok; int e0;
    buf_len = 5; pops_base = pops; e0 = errs;
    send_req(3'd1);
    foreach (exp[i]) begin
      get_byte(b, ok); checks++;
      if (!ok || b !== exp[i]) begin failures++; $display("FAIL uf_byte%0d got %h exp %h", i, b, exp[i]); end
    end
    ovr_en = 1'b1; bus.byte_req = 1'b1;
    #1; checks++;
    if (bus.get_tx_packet_data !== 1'b0) begin failures++; $display("FAIL uf_no_pop got %b exp 0", bus.get_tx_packet_data); end
    @(posedge tb_clk); #1; checks++;
    if (bus.tx_error !== 1'b1 || bus.eop_req !== 1'b1) begin
      failures++; $display("FAIL uf_abort err=%b eop_req=%b exp 1/1", bus.tx_error, bus.eop_req);
    end
    @(negedge tb_clk); bus.byte_req = 1'b0;
    finish_eop(ok);
    repeat (2) @(negedge tb_clk);
    checks++;
    if (errs - e0 != 1) begin failures++; $display("FAIL uf_err_pulses got %0d exp 1", errs - e0); end
    checks++;
    if (pops - pops_base != 2) begin failures++; $display("FAIL uf_pops got %0d exp 2", pops - pops_base); end
    ovr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [3] = '{8'h80, 8'h4B, 8'h00};
    logic [7:0] ack [2] = '{8'h80, 8'hD2};
    logic [7:0] b; logic ok;
    buf_len = 10; pops_base = pops;
    send_req(3'd2);
    foreach (exp[i]) begin
      get_byte(b, ok); checks++;
      if (!ok || b !== exp[i]) begin failures++; $display("FAIL rm_byte%0d got %h exp %h", i, b, exp[i]); end
    end
    bus.byte_req = 1'b1;
    #2 n_rst = 1'b0;
    #1; checks++;
    if ({bus.get_tx_packet_data, bus.tx_byte_valid, bus.eop_req, bus.tx_busy, bus.tx_error} !== 5'b0 ||
        bus.tx_byte !== 8'h00) begin
      failures++;
      $display("FAIL rm_async_reset got %b/%h exp 00000/00", {bus.get_tx_packet_data, bus.tx_byte_valid,
               bus.eop_req, bus.tx_busy, bus.tx_error}, bus.tx_byte);
    end
    bus.byte_req = 1'b0;
    @(negedge tb_clk); n_rst = 1'b1;
    send_req(3'd3);
    foreach (ack[i]) begin
      get_byte(b, ok); checks++;
      if (!ok || b !== ack[i]) begin failures++; $display("FAIL rm_ack_byte%0d got %h exp %h", i, b, ack[i]); end
    end
    finish_eop(ok); checks++;
    if (!ok || bus.tx_busy !== 1'b0) begin failures++; $display("FAIL rm_ack_done ok=%b busy=%b exp 1/0", ok, bus.tx_busy); end
  endtask

  task automatic test_illegal_busy();
    logic [7:0] b; logic ok; int e0;
    e0 = errs;
    send_req(3'd6);
    checks++;
    if (bus.tx_error !== 1'b1 || bus.tx_busy !== 1'b0) begin
      failures++; $display("FAIL ill_pulse err=%b busy=%b exp 1/0", bus.tx_error, bus.tx_busy);
    end
    @(negedge tb_clk); checks++;
    if (bus.tx_error !== 1'b0 || bus.tx_busy !== 1'b0) begin
      failures++; $display("FAIL ill_single err=%b busy=%b exp 0/0", bus.tx_error, bus.tx_busy);
    end
    send_req(3'd3);
    get_byte(b, ok); checks++;
    if (!ok || b !== 8'h80) begin failures++; $display("FAIL busy_sync got %h exp 80", b); end
    send_req(3'd1);
    send_req(3'd7);
    get_byte(b, ok); checks++;
    if (!ok || b !== 8'hD2) begin failures++; $display("FAIL busy_pid got %h exp d2", b); end
    finish_eop(ok);
    @(negedge tb_clk); checks++;
    if (!ok || bus.tx_busy !== 1'b0) begin failures++; $display("FAIL busy_no_requeue ok=%b busy=%b exp 1/0", ok, bus.tx_busy); end
    checks++;
    if (errs - e0 != 1) begin failures++; $display("FAIL busy_err_pulses got %0d exp 1", errs - e0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ack();
    test_data0_zero();
    test_data1_full();
    test_underflow();
    test_reset_mid();
    test_illegal_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_packet_ctrl.md
TX_PACKET_CTRL -- requirements
Module: tx_packet_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port tx_packet, input, 3 bits: packet request code; 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6-7 illegal.
REQ-004 SHALL have port buffer_occupancy, input, 7 bits: byte count from the packet buffer.
REQ-005 SHALL have port tx_packet_data, input, 8 bits: head byte of the packet buffer.
REQ-006 SHALL have port byte_req, input, 1 bit: single-cycle pulse from the encoder; it consumes the current tx_byte.
REQ-007 SHALL have port eop_done, input, 1 bit: pulse from the encoder when end-of-packet signalling completes.
REQ-008 SHALL have port get_tx_packet_data, output, 1 bit: pop strobe to the buffer.
REQ-009 SHALL have port tx_byte, output, 8 bits: byte presented to the encoder.
REQ-010 SHALL have port tx_byte_valid, output, 1 bit: tx_byte is meaningful.
REQ-011 SHALL have port eop_req, output, 1 bit: request to the encoder for EOP signalling.
REQ-012 SHALL have port tx_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port tx_error, output, 1 bit: single-cycle error pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP.
REQ-015 In IDLE, a legal non-NONE tx_packet SHALL latch the packet type and, for DATA0/DATA1 only, len = min(buffer_occupancy, 64), and SHALL move to SYNC on the next edge.
REQ-016 Illegal codes 6-7 in IDLE SHALL pulse tx_error for one cycle and leave the FSM in IDLE.
REQ-017 tx_packet SHALL be ignored while tx_busy is high.
REQ-018 tx_byte SHALL be combinational from state, as follows:
- SYNC: 0x80
- PID: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E
- DATA: tx_packet_data
- CRC_LO: low byte of the inverted CRC
- CRC_HI: high byte of the inverted CRC
REQ-019 tx_byte_valid SHALL be high in SYNC, PID, DATA, CRC_LO and CRC_HI, and low otherwise.
REQ-020 On each byte_req the FSM SHALL advance one byte, as follows:
- SYNC goes to PID.
- PID goes to DATA if the type is DATA and len > 0.
- PID goes to CRC_LO if the type is DATA and len = 0.
- PID goes to EOP for handshake types.
- DATA decrements the remaining count; the last byte goes to CRC_LO.
- CRC_LO goes to CRC_HI; CRC_HI goes to EOP.
REQ-021 get_tx_packet_data SHALL equal byte_req AND (state == DATA), in the same cycle, with no extra latency; it pulses exactly len times per DATA packet.
REQ-022 CRC SHALL be USB CRC16: polynomial 0x8005, reflected (LSB-first), initial value 0xFFFF, updated per consumed DATA byte, and transmitted inverted, low byte first.
- A zero-length packet therefore transmits 0x00 0x00.
REQ-023 eop_req SHALL be high throughout EOP; eop_done in EOP SHALL return the FSM to IDLE.
REQ-024 Underflow: if the FSM is in DATA with remaining > 0 and buffer_occupancy == 0, it SHALL pulse tx_error, issue no pop, and go to EOP.
REQ-025 byte_req outside byte-emitting states SHALL be ignored; eop_done outside EOP SHALL be ignored.

Reset
REQ-026 On n_rst low (asynchronous) the block SHALL immediately enter the following state, including mid-packet:
- state IDLE
- all counters and the latched type zero
- CRC = 0xFFFF
- get_tx_packet_data, tx_byte_valid, eop_req, tx_busy and tx_error all 0
- tx_byte 0x00

Structure
REQ-027 Package usb_pkg SHALL hold the tx_packet code enum, the PID byte constants, the FSM state enum, and the constants SYNC_BYTE = 0x80 and MAX_PACKET = 64.
REQ-028 The CRC SHALL be a sub-module crc16_usb with these ports:
- clk and n_rst
- clear (1 bit)
- enable (1 bit)
- data (8 bits)
- crc (16 bits)
It updates one byte per cycle.

Verification
REQ-029 ACK request, byte_req pulsed: tx_byte sequence 0x80, 0xD2; then eop_req; eop_done returns to IDLE; zero pops.
REQ-030 DATA0 with buffer_occupancy 0: sequence 0x80, 0xC3, 0x00, 0x00; then EOP; zero pops.
REQ-031 DATA1 with 64 bytes valued 0..63: sequence 0x80, 0x4B, 0x00..0x3F, then two CRC bytes matching the bench CRC16 model; exactly 64 pops.
REQ-032 DATA0 latched with len 5, buffer drained to 0 after 2 bytes: tx_error pulses once, 2 pops total, EOP follows.
REQ-033 n_rst asserted mid-DATA: all outputs 0 within the same cycle; a following ACK request runs normally.
REQ-034 tx_packet = 6 in IDLE gives one tx_error pulse and tx_busy stays 0; a new request issued while busy is ignored.
